prefetch_queue: RTL and testbench
=================================

Name: prefetch_queue

Overview:
- Parametrised successor to the single-entry FIFO: a multi-lane byte queue that accepts 0..LANES bytes per write and releases 0..LANES bytes per read in one cycle.
- Supports non-power-of-2 depth and a synchronous flush.
- Sits between the BIU bus fetch path (16-bit words, or a single byte after an odd-address jump) and the EU instruction decoder, which consumes 1 or 2 opcode bytes per cycle.
- Default configuration is the 8086 6-byte prefetch queue.

Parameters:
- WIDTH_DATA, 8, bits per entry (byte).
- DEPTH, 6, number of entries; any value >= LANES, not restricted to powers of 2.
- LANES, 2, maximum entries written or read per cycle; lane 0 is the oldest/first byte.

Ports:
- clock  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low (0 = reset); clears all state immediately.
- flush  input  1  synchronous clear: empties the queue on the next edge.
- write_count  input  $clog2(LANES+1)  bytes offered this cycle (0..LANES); 0 means no write.
- write_data  input  LANES*WIDTH_DATA  lane k in bits [k*WIDTH_DATA +: WIDTH_DATA]; lane 0 is enqueued first.
- read_count  input  $clog2(LANES+1)  bytes consumed this cycle (0..LANES).
- read_data  output  LANES*WIDTH_DATA  combinational view of the oldest LANES entries; lane 0 = head; lanes at index >= level read 0.
- level  output  $clog2(DEPTH+1)  current occupancy, 0..DEPTH.
- space  output  $clog2(DEPTH+1)  DEPTH - level.
- empty  output  1  level == 0.
- full  output  1  level == DEPTH.
- write_reject  output  1  registered one-cycle pulse: previous write refused.
- read_reject  output  1  registered one-cycle pulse: previous read refused.

Behaviour:
- Reset (reset = 0, asynchronous):
  - head and tail pointers cleared; level = 0; storage cleared to 0.
  - empty = 1, full = 0, space = DEPTH, rejects = 0, read_data = 0.
  - Reset asserted mid-operation discards all contents within the same cycle.
- Release: state is held until the first rising edge with reset = 1.
- Pointers:
  - head and tail range 0..DEPTH-1.
  - Advance by n with explicit modulo-DEPTH wrap: (p + n >= DEPTH) ? p + n - DEPTH : p + n.
  - No power-of-2 masking.
- Read acceptance: accepted iff read_count <= level (current level, before this cycle's write).
  - Accepted: head advances by read_count.
  - Refused: no state change; read_reject = 1 next cycle.
  - read_count = 0: never refused.
- Write acceptance: accepted iff write_count <= space (current space, before this cycle's read).
  - This is conservative: no same-cycle bypass of freed entries.
  - Accepted: lane k is stored at (tail + k) mod DEPTH for k < write_count; tail advances by write_count.
  - Refused: nothing is stored (all or nothing); write_reject = 1 next cycle.
- Simultaneous accepted read and write: level_next = level + write_count - read_count.
  - Width: computed in $clog2(DEPTH+1)+1 bits, then truncated; it cannot exceed DEPTH by construction.
- Read latency:
  - read_data is combinational from storage and head; no read latency.
  - A byte written at edge N is visible on read_data after edge N.
  - A byte is never readable in the cycle it is written (no write-to-read bypass).
- Flush:
  - Highest priority below reset.
  - Next edge: head = tail = 0, level = 0.
  - Same-cycle write and read are discarded; rejects are not raised.
- Illegal input: write_count or read_count > LANES is treated as a refusal, and the matching reject pulses.
- Flags: empty, full, space and level are all derived from the level register; all change only on edges (or on reset).

Decomposition:
- Shared package pkg_queue holds:
  - typedef count_t (logic [$clog2(LANES+1)-1:0]);
  - typedef level_t (logic [$clog2(DEPTH+1)-1:0]);
  - localparams for the default configuration: QUEUE_DEPTH = 6, QUEUE_LANES = 2, QUEUE_WIDTH = 8.
- One sub-module: queue_pointer. It is a parametrised modulo-DEPTH register with async active-low reset, synchronous clear, and advance-by-n. It is instantiated twice, once for head and once for tail.

Test Plan:
1. Reset then idle -> level = 0, empty = 1, space = 6, read_data = 0x0000; hold reset low mid-stream after 3 writes -> all flags return to their reset values immediately.
2. Write 2 lanes {0x22,0x11}, then 1 lane 0x33 -> level = 3, read_data = {0x22,0x11}; read 1 -> read_data = {0x33,0x22}, level = 2.
3. Fill to 6 with three 2-lane writes, then write 1 -> write_reject pulses one cycle, level stays 6, full = 1; contents unchanged on read-out (order 1..6).
4. Wrap-around: write 4, read 4, write 3 pairs {0xA0..0xA5} -> tail wraps past index 5, read 2 per cycle returns A0/A1, A2/A3, A4/A5 in order, empty = 1 at end.
5. Level = 1, read_count = 2 -> read_reject pulses, level stays 1; same cycle write 2 with space = 5 -> accepted, level = 3.
6. Level = 4, flush with simultaneous write 2 and read 1 -> next cycle level = 0, empty = 1, no reject pulse; a subsequent write of 0x55 appears at read_data lane 0.

Source files
------------

// File: rtl/prefetch_queue_pkg.sv
// Shared definitions for the prefetch queue.
//   - Default configuration (the 8086 6-byte prefetch queue).
//   - count_t / level_t widths for that configuration.
//   - wrap_index: modulo-depth index arithmetic shared by the storage addressing.
package pkg_queue;

  localparam int unsigned QUEUE_DEPTH = 32'd6;
  localparam int unsigned QUEUE_LANES = 32'd2;
  localparam int unsigned QUEUE_WIDTH = 32'd8;

  typedef logic [$clog2(QUEUE_LANES+1)-1:0] count_t;
  typedef logic [$clog2(QUEUE_DEPTH+1)-1:0] level_t;

  // Index of base + offset in a ring of 'depth' slots. The callers guarantee
  // base < depth and offset <= depth, so one conditional subtraction suffices
  // and no power-of-2 masking is involved.
  function automatic int unsigned wrap_index(input int unsigned base,
                                             input int unsigned offset,
                                             input int unsigned depth);
    int unsigned sum;
    sum = base + offset;
    if (sum >= depth) begin
      return sum - depth;
    end else begin
      return sum;
    end
  endfunction

endpackage

// File: rtl/prefetch_queue_pointer.sv
// Modulo-DEPTH ring pointer used for both the head and tail of the queue.
// Ports:
//   clock   - rising-edge clock
//   reset   - asynchronous active-low reset, pointer returns to 0
//   clear   - synchronous clear to 0 (takes priority over advance)
//   advance - move the pointer forward by 'step' on this edge
//   step    - advance amount, 0..LANES (only meaningful when advance = 1)
//   ptr     - current pointer value, 0..DEPTH-1
module queue_pointer
  import pkg_queue::*;
#(
  parameter int unsigned DEPTH = QUEUE_DEPTH,
  parameter int unsigned LANES = QUEUE_LANES
) (
  input  logic                                       clock,
  input  logic                                       reset,
  input  logic                                       clear,
  input  logic                                       advance,
  input  logic [$clog2(LANES+1)-1:0]                 step,
  output logic [((DEPTH > 1) ? $clog2(DEPTH) : 1)-1:0] ptr
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(LANES+1);
  localparam int unsigned SW = ((PW > CW) ? PW : CW) + 1;

  logic [SW-1:0] sum_s;
  logic [PW-1:0] ptr_next_s;
  logic [PW-1:0] ptr_r;

  // Next pointer value: explicit wrap at DEPTH, valid for any depth.
  always_comb begin
    sum_s = SW'(ptr_r) + SW'(step);
    if (sum_s >= SW'(DEPTH)) begin
      ptr_next_s = PW'(sum_s - SW'(DEPTH));
    end else begin
      ptr_next_s = PW'(sum_s);
    end
  end

  // Pointer register with async reset, sync clear and conditional advance.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr_r <= '0;
    end else if (clear) begin
      ptr_r <= '0;
    end else if (advance) begin
      ptr_r <= ptr_next_s;
    end else begin
      ptr_r <= ptr_r;
    end
  end

  assign ptr = ptr_r;

endmodule

// File: rtl/prefetch_queue.sv
// Multi-lane byte queue between the bus fetch path and the instruction decoder.
// Accepts 0..LANES entries per write and releases 0..LANES entries per read in
// a single cycle. Depth need not be a power of 2.
// Ports:
//   clock        - rising-edge clock
//   reset        - asynchronous active-low reset, clears all state
//   flush        - synchronous empty on the next edge, discards same-cycle traffic
//   write_count  - entries offered this cycle (0..LANES)
//   write_data   - lane k in [k*WIDTH_DATA +: WIDTH_DATA], lane 0 enqueued first
//   read_count   - entries consumed this cycle (0..LANES)
//   read_data    - combinational view of the oldest LANES entries, lane 0 = head,
//                  lanes at or beyond the current level read 0
//   level/space  - occupancy and free slots
//   empty/full   - occupancy flags
//   write_reject - one-cycle pulse: the previous cycle's write was refused
//   read_reject  - one-cycle pulse: the previous cycle's read was refused
module prefetch_queue
  import pkg_queue::*;
#(
  parameter int unsigned WIDTH_DATA = QUEUE_WIDTH,
  parameter int unsigned DEPTH      = QUEUE_DEPTH,
  parameter int unsigned LANES      = QUEUE_LANES
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          flush,
  input  logic [$clog2(LANES+1)-1:0]    write_count,
  input  logic [LANES*WIDTH_DATA-1:0]   write_data,
  input  logic [$clog2(LANES+1)-1:0]    read_count,
  output logic [LANES*WIDTH_DATA-1:0]   read_data,
  output logic [$clog2(DEPTH+1)-1:0]    level,
  output logic [$clog2(DEPTH+1)-1:0]    space,
  output logic                          empty,
  output logic                          full,
  output logic                          write_reject,
  output logic                          read_reject
);

  localparam int unsigned CW = $clog2(LANES+1);
  localparam int unsigned LW = $clog2(DEPTH+1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned XW = ((LW > CW) ? LW : CW) + 1;

  logic [WIDTH_DATA-1:0] mem_r [DEPTH];
  logic [LW-1:0]         level_r;
  logic                  write_reject_r;
  logic                  read_reject_r;

  logic [PW-1:0]         head_s;
  logic [PW-1:0]         tail_s;
  logic [LW-1:0]         space_s;
  logic                  rd_ok_s;
  logic                  wr_ok_s;
  logic                  rd_acc_s;
  logic                  wr_acc_s;
  logic [CW-1:0]         rd_step_s;
  logic [CW-1:0]         wr_step_s;

  assign space_s = LW'(DEPTH) - level_r;

  // Acceptance decisions. Both use the pre-edge level/space, so a write
  // never relies on entries freed by a read in the same cycle. Counts above
  // LANES are illegal and refused.
  always_comb begin
    rd_ok_s  = (XW'(read_count) <= XW'(LANES)) && (XW'(read_count) <= XW'(level_r));
    wr_ok_s  = (XW'(write_count) <= XW'(LANES)) && (XW'(write_count) <= XW'(space_s));
    rd_acc_s = !flush && rd_ok_s;
    wr_acc_s = !flush && wr_ok_s;
    if (rd_acc_s) begin
      rd_step_s = read_count;
    end else begin
      rd_step_s = '0;
    end
    if (wr_acc_s) begin
      wr_step_s = write_count;
    end else begin
      wr_step_s = '0;
    end
  end

  queue_pointer #(
    .DEPTH (DEPTH),
    .LANES (LANES)
  ) u_head (
    .clock   (clock),
    .reset   (reset),
    .clear   (flush),
    .advance (rd_acc_s),
    .step    (read_count),
    .ptr     (head_s)
  );

  queue_pointer #(
    .DEPTH (DEPTH),
    .LANES (LANES)
  ) u_tail (
    .clock   (clock),
    .reset   (reset),
    .clear   (flush),
    .advance (wr_acc_s),
    .step    (write_count),
    .ptr     (tail_s)
  );

  // Occupancy register. The sum is formed one bit wider than level so the
  // intermediate level + write_count cannot overflow before the subtraction.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      level_r <= '0;
    end else if (flush) begin
      level_r <= '0;
    end else begin
      level_r <= LW'(XW'(level_r) + XW'(wr_step_s) - XW'(rd_step_s));
    end
  end

  // Reject pulses: one cycle high after a refused request; suppressed by flush.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      write_reject_r <= 1'b0;
      read_reject_r  <= 1'b0;
    end else if (flush) begin
      write_reject_r <= 1'b0;
      read_reject_r  <= 1'b0;
    end else begin
      write_reject_r <= !wr_ok_s;
      read_reject_r  <= !rd_ok_s;
    end
  end

  // Storage: lanes below write_count land at tail, tail+1, ... modulo DEPTH.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (wr_acc_s) begin
      for (int unsigned k = 0; k < LANES; k++) begin
        if (k < 32'(write_count)) begin
          mem_r[PW'(wrap_index(32'(tail_s), k, DEPTH))] <= write_data[k*WIDTH_DATA +: WIDTH_DATA];
        end
      end
    end
  end

  // Head-aligned read window; lanes beyond the occupancy are forced to 0 so
  // stale storage never leaks out.
  always_comb begin
    read_data = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      if (32'(level_r) > k) begin
        read_data[k*WIDTH_DATA +: WIDTH_DATA] = mem_r[PW'(wrap_index(32'(head_s), k, DEPTH))];
      end else begin
        read_data[k*WIDTH_DATA +: WIDTH_DATA] = '0;
      end
    end
  end

  assign level        = level_r;
  assign space        = space_s;
  assign empty        = (level_r == LW'(0));
  assign full         = (level_r == LW'(DEPTH));
  assign write_reject = write_reject_r;
  assign read_reject  = read_reject_r;

endmodule

// File: tb/tb_prefetch_queue.sv
module tb_prefetch_queue;
  import pkg_queue::*;

  logic        clock;
  logic        reset;
  logic        flush;
  count_t      write_count;
  logic [15:0] write_data;
  count_t      read_count;
  logic [15:0] read_data;
  level_t      level;
  level_t      space;
  logic        empty;
  logic        full;
  logic        write_reject;
  logic        read_reject;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a byte queue plus the two expected reject flags.
  logic [7:0] mq[$];
  bit         m_wrej;
  bit         m_rrej;
  bit         check_en;

  prefetch_queue dut (
    .clock        (clock),
    .reset        (reset),
    .flush        (flush),
    .write_count  (write_count),
    .write_data   (write_data),
    .read_count   (read_count),
    .read_data    (read_data),
    .level        (level),
    .space        (space),
    .empty        (empty),
    .full         (full),
    .write_reject (write_reject),
    .read_reject  (read_reject)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of traffic to the model using the rules for a whole queue:
  // reads need enough bytes, writes need enough free slots (both pre-edge).
  task automatic model_update(input int wc, input logic [15:0] wd, input int rc, input bit fl);
    bit rd_ok;
    bit wr_ok;
    int sz;
    if (fl) begin
      mq.delete();
      m_wrej = 1'b0;
      m_rrej = 1'b0;
    end else begin
      sz    = mq.size();
      rd_ok = (rc <= 2) && (rc <= sz);
      wr_ok = (wc <= 2) && (wc <= 6 - sz);
      if (rd_ok) repeat (rc) void'(mq.pop_front());
      if (wr_ok) for (int k = 0; k < wc; k++) mq.push_back(wd[k*8 +: 8]);
      m_wrej = !wr_ok;
      m_rrej = !rd_ok;
    end
  endtask

  // Drive one cycle; returns at the following falling edge.
  task automatic step(input int wc, input logic [15:0] wd, input int rc, input bit fl);
    write_count = count_t'(wc);
    write_data  = wd;
    read_count  = count_t'(rc);
    flush       = fl;
    @(posedge clock);
    model_update(wc, wd, rc, fl);
    @(negedge clock);
    write_count = '0;
    write_data  = '0;
    read_count  = '0;
    flush       = 1'b0;
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clock) begin
    logic [15:0] exp_rd;
    if (check_en) begin
      exp_rd = '0;
      for (int k = 0; k < 2; k++) if (k < mq.size()) exp_rd[k*8 +: 8] = mq[k];
      check("read_data", 32'(read_data), 32'(exp_rd));
      check("level", 32'(level), 32'(mq.size()));
      check("space", 32'(space), 32'(6 - mq.size()));
      check("empty", 32'(empty), 32'(mq.size() == 0));
      check("full", 32'(full), 32'(mq.size() == 6));
      check("write_reject", 32'(write_reject), 32'(m_wrej));
      check("read_reject", 32'(read_reject), 32'(m_rrej));
    end
  end

  initial begin
    reset       = 1'b0;
    flush       = 1'b0;
    write_count = '0;
    write_data  = '0;
    read_count  = '0;
    m_wrej      = 1'b0;
    m_rrej      = 1'b0;
    check_en    = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b1;

    // 1: reset then idle, then async reset mid-stream
    step(0, 16'h0000, 0, 1'b0);
    check("t1_level", 32'(level), 32'd0);
    check("t1_empty", 32'(empty), 32'd1);
    check("t1_space", 32'(space), 32'd6);
    check("t1_rdata", 32'(read_data), 32'h0000);
    step(1, 16'h0001, 0, 1'b0);
    step(1, 16'h0002, 0, 1'b0);
    step(1, 16'h0003, 0, 1'b0);
    check("t1_level3", 32'(level), 32'd3);
    #2 reset = 1'b0;
    mq.delete();
    m_wrej = 1'b0;
    m_rrej = 1'b0;
    #1;
    check("t1_rst_level", 32'(level), 32'd0);
    check("t1_rst_empty", 32'(empty), 32'd1);
    check("t1_rst_full", 32'(full), 32'd0);
    check("t1_rst_space", 32'(space), 32'd6);
    check("t1_rst_rdata", 32'(read_data), 32'h0000);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;

    // 2: mixed-width writes then a single-byte read
    step(2, 16'h2211, 0, 1'b0);
    step(1, 16'h0033, 0, 1'b0);
    check("t2_level", 32'(level), 32'd3);
    check("t2_rdata", 32'(read_data), 32'h2211);
    step(0, 16'h0000, 1, 1'b0);
    check("t2_rdata_after", 32'(read_data), 32'h3322);
    check("t2_level_after", 32'(level), 32'd2);
    step(0, 16'h0000, 2, 1'b0);

    // 3: fill to capacity, overflow write refused, order preserved
    step(2, 16'h0201, 0, 1'b0);
    step(2, 16'h0403, 0, 1'b0);
    step(2, 16'h0605, 0, 1'b0);
    step(1, 16'h0007, 0, 1'b0);
    check("t3_wrej", 32'(write_reject), 32'd1);
    check("t3_level", 32'(level), 32'd6);
    check("t3_full", 32'(full), 32'd1);
    step(0, 16'h0000, 0, 1'b0);
    check("t3_wrej_clear", 32'(write_reject), 32'd0);
    check("t3_rd01", 32'(read_data), 32'h0201);
    step(0, 16'h0000, 2, 1'b0);
    check("t3_rd23", 32'(read_data), 32'h0403);
    step(0, 16'h0000, 2, 1'b0);
    check("t3_rd45", 32'(read_data), 32'h0605);
    step(0, 16'h0000, 2, 1'b0);

    // 4: wrap-around of both pointers
    step(2, 16'h1111, 0, 1'b0);
    step(2, 16'h2222, 0, 1'b0);
    step(0, 16'h0000, 2, 1'b0);
    step(0, 16'h0000, 2, 1'b0);
    step(2, 16'hA1A0, 0, 1'b0);
    step(2, 16'hA3A2, 0, 1'b0);
    step(2, 16'hA5A4, 0, 1'b0);
    check("t4_rd_a0", 32'(read_data), 32'hA1A0);
    step(0, 16'h0000, 2, 1'b0);
    check("t4_rd_a2", 32'(read_data), 32'hA3A2);
    step(0, 16'h0000, 2, 1'b0);
    check("t4_rd_a4", 32'(read_data), 32'hA5A4);
    step(0, 16'h0000, 2, 1'b0);
    check("t4_empty", 32'(empty), 32'd1);

    // 5: read underflow refused while same-cycle write proceeds
    step(1, 16'h0077, 0, 1'b0);
    step(2, 16'h9988, 2, 1'b0);
    check("t5_rrej", 32'(read_reject), 32'd1);
    check("t5_wrej", 32'(write_reject), 32'd0);
    check("t5_level", 32'(level), 32'd3);
    check("t5_rdata", 32'(read_data), 32'h8877);
    step(0, 16'h0000, 0, 1'b0);
    check("t5_rrej_clear", 32'(read_reject), 32'd0);

    // illegal counts above LANES are refused
    step(3, 16'h1234, 0, 1'b0);
    check("ill_wrej", 32'(write_reject), 32'd1);
    check("ill_wlevel", 32'(level), 32'd3);
    step(0, 16'h0000, 3, 1'b0);
    check("ill_rrej", 32'(read_reject), 32'd1);
    check("ill_rlevel", 32'(level), 32'd3);

    // 6: flush beats simultaneous write and read
    step(1, 16'h0066, 0, 1'b0);
    check("t6_level4", 32'(level), 32'd4);
    step(2, 16'hBBAA, 1, 1'b1);
    check("t6_level", 32'(level), 32'd0);
    check("t6_empty", 32'(empty), 32'd1);
    check("t6_wrej", 32'(write_reject), 32'd0);
    check("t6_rrej", 32'(read_reject), 32'd0);
    step(1, 16'h0055, 0, 1'b0);
    check("t6_rdata", 32'(read_data), 32'h0055);

    // random traffic, checked every cycle by the compare process
    for (int i = 0; i < 300; i++) begin
      step(int'($urandom_range(0, 3)), 16'($urandom), int'($urandom_range(0, 3)),
           ($urandom_range(0, 19) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
